// File: rtl/aes_spi_master_if.sv
// Host-facing and serial signals of the AES SPI master, with the design side
// (master) and the host/slave side (slave) as modports.
interface aes_spi_master_if #(
  parameter int Nk = 4
);
  logic              start;
  logic [127:0]      data_in;
  logic [32*Nk-1:0]  key_in;
  logic              busy;
  logic              done;
  logic [127:0]      data_out;
  logic              SCLK;
  logic              CS;
  logic              SDO;
  logic              SDI;

  modport master (
    input  start, data_in, key_in, SDI,
    output busy, done, data_out, SCLK, CS, SDO
  );

  modport slave (
    output start, data_in, key_in, SDI,
    input  busy, done, data_out, SCLK, CS, SDO
  );
endinterface

// File: rtl/aes_spi_master.sv
// SPI mode-0 master for the AES slave: shifts out {block, key} MSB-first,
// idles TURN periods, then shifts in the 128-bit result.
module aes_spi_master #(
  parameter int Nk      = 4,
  parameter int CLK_DIV = 2,
  parameter int TURN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  aes_spi_master_if.master bus
);

  localparam int L  = 128 + 32*Nk;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [8:0]    TX_LAST   = 9'(L - 1);
  localparam logic [8:0]    TURN_LAST = 9'(TURN - 1);
  localparam logic [8:0]    RX_LAST   = 9'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURNA,
    S_RX,
    S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_div;
  logic [8:0]      r_bit;
  logic            r_sclk;
  logic [L-1:0]    r_shift;
  logic [127:0]    r_data_out;
  logic            r_cs;
  logic            r_busy;
  logic            r_done;
  logic            w_cs;
  logic            w_busy;
  logic            w_done;
  logic            w_active;
  logic            w_div_end;
  logic            w_rise;
  logic            w_fall;

  assign w_active  = (r_state == S_TX) || (r_state == S_TURNA) || (r_state == S_RX);
  assign w_div_end = (r_div == DIV_MAX);
  assign w_rise    = w_active && w_div_end && !r_sclk;
  assign w_fall    = w_active && w_div_end && r_sclk;

  // Control outputs are registered from the next state so CS/busy/done are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)                      w_state_nxt = S_TX;
      S_TX:    if (w_fall && r_bit == TX_LAST)     w_state_nxt = S_TURNA;
      S_TURNA: if (w_fall && r_bit == TURN_LAST)   w_state_nxt = S_RX;
      S_RX:    if (w_fall && r_bit == RX_LAST)     w_state_nxt = S_FIN;
      S_FIN:                                       w_state_nxt = S_IDLE;
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (w_state_nxt == S_TX) || (w_state_nxt == S_TURNA) || (w_state_nxt == S_RX);
    w_cs   = !w_busy;
    w_done = (w_state_nxt == S_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_sclk     <= 1'b0;
      r_shift    <= '0;
      r_data_out <= '0;
    end else if (r_state == S_IDLE) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
      if (bus.start) r_shift <= {bus.data_in, bus.key_in};
    end else if (w_active) begin
      if (w_div_end) begin
        r_div  <= '0;
        r_sclk <= !r_sclk;
      end else begin
        r_div  <= r_div + DW'(1);
      end
      // A period ends on the falling phase; that is where SDO and the bit count advance.
      if (w_fall) begin
        r_bit <= (w_state_nxt != r_state) ? '0 : r_bit + 9'd1;
        if (r_state == S_TX) r_shift <= {r_shift[L-2:0], 1'b0};
      end
      if (w_rise && r_state == S_RX) r_data_out <= {r_data_out[126:0], bus.SDI};
    end else begin
      r_div  <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
    end
  end

  assign bus.SCLK     = r_sclk;
  assign bus.CS       = r_cs;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.data_out = r_data_out;
  assign bus.SDO      = (r_state == S_TX) && r_shift[L-1];

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master: three configurations, each with a
// behavioural mode-0 slave that answers with a known result.
module tb_aes_spi_master;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY4  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT4   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT8   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PAT   = {16{8'ha5}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_spi_master_if #(.Nk(4)) b4();
  aes_spi_master_if #(.Nk(8)) b8();
  aes_spi_master_if #(.Nk(4)) b1();

  aes_spi_master #(.Nk(4), .CLK_DIV(2), .TURN(1)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  aes_spi_master #(.Nk(8), .CLK_DIV(2), .TURN(1)) dut8 (.clk(clk), .rst(rst), .bus(b8.master));
  aes_spi_master #(.Nk(4), .CLK_DIV(1), .TURN(3)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  int n_vec = 0;
  int n_err = 0;

  // Slave for dut4: frame of 256 bits, TURNA period 256, RX periods 257..384.
  logic [255:0] f4;
  int           r4 = 0;
  logic         m4 = 1'b0;
  logic [127:0] resp4;
  assign resp4 = (f4 == {PT, KEY4}) ? CT4 : '0;
  always @(posedge b4.SCLK or negedge b4.CS) begin
    if (!b4.CS && b4.SCLK) begin
      if (r4 < 256) f4 = {f4[254:0], b4.SDO};
      r4++;
    end else if (!b4.CS) r4 = 0;
  end
  always @(negedge b4.SCLK) if (!b4.CS) begin
    if (r4 == 256)                b4.SDI = m4;
    else if (r4 > 256 && r4 < 385) b4.SDI = m4 ? 1'b0 : resp4[384-r4];
    else                          b4.SDI = 1'b0;
  end

  // Slave for dut8: frame of 384 bits, TURNA period 384, RX periods 385..512.
  logic [383:0] f8;
  int           r8 = 0;
  logic [127:0] resp8;
  assign resp8 = (f8 == {PT, KEY8}) ? CT8 : '0;
  always @(posedge b8.SCLK or negedge b8.CS) begin
    if (!b8.CS && b8.SCLK) begin
      if (r8 < 384) f8 = {f8[382:0], b8.SDO};
      r8++;
    end else if (!b8.CS) r8 = 0;
  end
  always @(negedge b8.SCLK) if (!b8.CS) begin
    if (r8 > 384 && r8 < 513) b8.SDI = resp8[512-r8];
    else                      b8.SDI = 1'b0;
  end

  // Loopback slave for dut1: TURNA periods 256..258, RX periods 259..386.
  int           r1 = 0;
  logic [127:0] pat1;
  assign pat1 = PAT;
  always @(posedge b1.SCLK or negedge b1.CS) begin
    if (!b1.CS && b1.SCLK) r1++;
    else if (!b1.CS) r1 = 0;
  end
  always @(negedge b1.SCLK) if (!b1.CS) begin
    if (r1 > 258 && r1 < 387) b1.SDI = pat1[386-r1];
    else                      b1.SDI = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start dut4 and wait for done; done_cyc counts from 1 = first cycle after acceptance.
  task automatic run4(output int done_cyc, output logic [127:0] dout);
    int cyc;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    cyc = 1;
    while (!b4.done && cyc < 3000) begin
      step();
      cyc++;
    end
    done_cyc = b4.done ? cyc : -1;
    dout     = b4.data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.start = 1'b0; b8.start = 1'b0; b1.start = 1'b0;
    b4.data_in = PT; b4.key_in = KEY4;
    b8.data_in = PT; b8.key_in = KEY8;
    b1.data_in = PT; b1.key_in = KEY4;
    step();
    n_vec++; if (b4.busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", b4.busy); end
    n_vec++; if (b4.done !== 1'b0)     begin n_err++; $display("FAIL reset_done got %b want 0", b4.done); end
    n_vec++; if (b4.data_out !== '0)   begin n_err++; $display("FAIL reset_data_out got %h want 0", b4.data_out); end
    n_vec++; if (b4.SCLK !== 1'b0)     begin n_err++; $display("FAIL reset_sclk got %b want 0", b4.SCLK); end
    n_vec++; if (b4.CS !== 1'b1)       begin n_err++; $display("FAIL reset_cs got %b want 1", b4.CS); end
    n_vec++; if (b4.SDO !== 1'b0)      begin n_err++; $display("FAIL reset_sdo got %b want 0", b4.SDO); end
    n_vec++; if (b8.CS !== 1'b1)       begin n_err++; $display("FAIL reset_cs8 got %b want 1", b8.CS); end
    n_vec++; if (b1.SCLK !== 1'b0)     begin n_err++; $display("FAIL reset_sclk1 got %b want 0", b1.SCLK); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_encrypt4();
    int dc;
    logic [127:0] d;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    n_vec++; if (b4.CS !== 1'b0 || b4.busy !== 1'b1 || b4.SDO !== PT[127] || b4.SCLK !== 1'b0)
      begin n_err++; $display("FAIL first_cycle got cs=%b busy=%b sdo=%b sclk=%b want 0 1 %b 0", b4.CS, b4.busy, b4.SDO, b4.SCLK, PT[127]); end
    dc = 1;
    while (!b4.done && dc < 3000) begin step(); dc++; end
    if (!b4.done) dc = -1;
    n_vec++; if (dc !== 1541)       begin n_err++; $display("FAIL enc4_done_cycle got %0d want 1541", dc); end
    n_vec++; if (b4.data_out !== CT4) begin n_err++; $display("FAIL enc4_data got %h want %h", b4.data_out, CT4); end
    n_vec++; if (f4 !== {PT, KEY4})  begin n_err++; $display("FAIL enc4_frame got %h want %h", f4, {PT, KEY4}); end
    n_vec++; if (r4 !== 385)        begin n_err++; $display("FAIL enc4_rises got %0d want 385", r4); end
    n_vec++; if (b4.busy !== 1'b0 || b4.CS !== 1'b1 || b4.SCLK !== 1'b0)
      begin n_err++; $display("FAIL enc4_fin got busy=%b cs=%b sclk=%b want 0 1 0", b4.busy, b4.CS, b4.SCLK); end
    step();
    n_vec++; if (b4.done !== 1'b0)   begin n_err++; $display("FAIL enc4_done_width got %b want 0", b4.done); end
    n_vec++; if (b4.data_out !== CT4) begin n_err++; $display("FAIL enc4_hold got %h want %h", b4.data_out, CT4); end
    run4(dc, d);
    n_vec++; if (d !== CT4)          begin n_err++; $display("FAIL enc4_repeat got %h want %h", d, CT4); end
  endtask

  task automatic test_aes256();
    int dc;
    b8.start = 1'b1;
    step();
    b8.start = 1'b0;
    dc = 1;
    while (!b8.done && dc < 3000) begin step(); dc++; end
    if (!b8.done) dc = -1;
    n_vec++; if (dc !== 2053)         begin n_err++; $display("FAIL aes256_done_cycle got %0d want 2053", dc); end
    n_vec++; if (f8 !== {PT, KEY8})   begin n_err++; $display("FAIL aes256_frame got %h want %h", f8, {PT, KEY8}); end
    n_vec++; if (b8.data_out !== CT8) begin n_err++; $display("FAIL aes256_data got %h want %h", b8.data_out, CT8); end
    n_vec++; if (r8 !== 513)          begin n_err++; $display("FAIL aes256_rises got %0d want 513", r8); end
    step();
  endtask

  task automatic test_loopback_div1();
    int dc, low, tog_err;
    logic prev;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    dc = 1; low = 0; tog_err = 0; prev = 1'b0;
    while (!b1.done && dc < 2000) begin
      if (!b1.CS) begin
        low++;
        if (low > 1 && b1.SCLK === prev) tog_err++;
      end
      prev = b1.SCLK;
      step();
      dc++;
    end
    if (!b1.done) dc = -1;
    n_vec++; if (dc !== 775)           begin n_err++; $display("FAIL div1_done_cycle got %0d want 775", dc); end
    n_vec++; if (low !== 774)          begin n_err++; $display("FAIL div1_cs_low got %0d want 774", low); end
    n_vec++; if (tog_err !== 0)        begin n_err++; $display("FAIL div1_toggle got %0d want 0", tog_err); end
    n_vec++; if (b1.data_out !== PAT)  begin n_err++; $display("FAIL div1_data got %h want %h", b1.data_out, PAT); end
    step();
  endtask

  task automatic test_start_ignored();
    int cyc, dc, nbl;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    cyc = 1; dc = -1; nbl = 0;
    while (cyc < 3000) begin
      if (b4.done) begin dc = cyc; break; end
      if (!b4.busy) nbl++;
      b4.start = (cyc == 5 || cyc == 100);
      step();
      cyc++;
    end
    n_vec++; if (dc !== 1541) begin n_err++; $display("FAIL ign_done_cycle got %0d want 1541", dc); end
    n_vec++; if (nbl !== 0)   begin n_err++; $display("FAIL ign_busy_gaps got %0d want 0", nbl); end
    b4.start = 1'b1;
    step();
    n_vec++; if (b4.busy !== 1'b0 || b4.CS !== 1'b1)
      begin n_err++; $display("FAIL ign_on_done got busy=%b cs=%b want 0 1", b4.busy, b4.CS); end
    step();
    b4.start = 1'b0;
    n_vec++; if (b4.busy !== 1'b1 || b4.CS !== 1'b0)
      begin n_err++; $display("FAIL ign_after_done got busy=%b cs=%b want 1 0", b4.busy, b4.CS); end
    cyc = 1;
    while (!b4.done && cyc < 3000) begin step(); cyc++; end
    if (!b4.done) cyc = -1;
    n_vec++; if (cyc !== 1541)        begin n_err++; $display("FAIL ign_second_cycle got %0d want 1541", cyc); end
    n_vec++; if (b4.data_out !== CT4) begin n_err++; $display("FAIL ign_second_data got %h want %h", b4.data_out, CT4); end
    step();
  endtask

  task automatic test_reset_mid();
    int ndone, ncs;
    int dc;
    logic [127:0] d;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    repeat (699) step();
    rst = 1'b1;
    #1;
    n_vec++; if (b4.CS !== 1'b1)     begin n_err++; $display("FAIL rmid_cs got %b want 1", b4.CS); end
    n_vec++; if (b4.SCLK !== 1'b0)   begin n_err++; $display("FAIL rmid_sclk got %b want 0", b4.SCLK); end
    n_vec++; if (b4.busy !== 1'b0)   begin n_err++; $display("FAIL rmid_busy got %b want 0", b4.busy); end
    n_vec++; if (b4.data_out !== '0) begin n_err++; $display("FAIL rmid_data got %h want 0", b4.data_out); end
    n_vec++; if (b4.SDO !== 1'b0)    begin n_err++; $display("FAIL rmid_sdo got %b want 0", b4.SDO); end
    step();
    rst = 1'b0;
    ndone = 0; ncs = 0;
    for (int i = 0; i < 2000; i++) begin
      if (b4.done) ndone++;
      if (!b4.CS) ncs++;
      step();
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL rmid_no_done got %0d want 0", ndone); end
    n_vec++; if (ncs !== 0)   begin n_err++; $display("FAIL rmid_cs_idle got %0d want 0", ncs); end
    run4(dc, d);
    n_vec++; if (dc !== 1541) begin n_err++; $display("FAIL rmid_restart_cycle got %0d want 1541", dc); end
    n_vec++; if (d !== CT4)   begin n_err++; $display("FAIL rmid_restart_data got %h want %h", d, CT4); end
    step();
  endtask

  task automatic test_turna_sampling();
    int dc;
    logic [127:0] d;
    m4 = 1'b1;
    run4(dc, d);
    m4 = 1'b0;
    n_vec++; if (dc !== 1541) begin n_err++; $display("FAIL turna_cycle got %0d want 1541", dc); end
    n_vec++; if (d !== '0)    begin n_err++; $display("FAIL turna_data got %h want 0", d); end
    step();
  endtask

  initial begin
    test_reset();
    test_encrypt4();
    test_aes256();
    test_loopback_div1();
    test_start_ignored();
    test_reset_mid();
    test_turna_sampling();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_spi_master.md
Name: aes_spi_master

Overview:
- SPI master that feeds the AES SPI slave: takes one 128-bit block plus a 32*Nk-bit key in parallel and serialises them MSB-first to the slave.
- Waits a programmable turnaround, then shifts in the 128-bit result and presents it in parallel with a one-cycle done pulse.
- Sits between the host/bus logic and the off-block AES SPI slave; one transaction per start.

Parameters:
- Nk, 4, key length in 32-bit words (legal: 4, 6, 8).
- CLK_DIV, 2, SCLK half-period in clk cycles (>=1).
- TURN, 1, idle SCLK periods between the last key bit and the first result bit (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin transaction; sampled only in IDLE.
- data_in  input  128  plaintext/ciphertext block, bit 127 sent first.
- key_in  input  32*Nk  key, MSB sent first after data.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when data_out is valid.
- data_out  output  128  received result, bit 127 = first bit received.
- SCLK  output  1  serial clock, idle low (mode 0).
- CS  output  1  chip select, active low, idle high.
- SDO  output  1  master out, to slave SDI.
- SDI  input  1  master in, from slave SDO.

Behaviour:
- Reset values: busy=0, done=0, data_out=0, SCLK=0, CS=1, SDO=0, all counters 0, state IDLE.
- States: IDLE -> TX -> TURNA -> RX -> FIN -> IDLE.
- IDLE: on start=1 at a clk edge, latch {data_in, key_in} into a (128+32*Nk)-bit shift register. On the next cycle CS=0, busy=1, SDO=data_in[127], SCLK=0.
- SCLK period: CLK_DIV cycles low, then CLK_DIV cycles high. The first low phase doubles as CS setup time.
- TX: 128+32*Nk periods. SDO updates to the next bit in the same cycle SCLK falls, and is stable across each rising edge.
- TURNA: TURN periods with SDO=0. SCLK keeps toggling.
- RX: 128 periods. SDI is sampled on the clk cycle in which SCLK goes high and shifted into data_out LSB-side, so the first sampled bit ends at bit 127. SDO=0.
- FIN: entered on the fall after the last RX high phase. CS=1, SCLK=0, done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: N = 256+32*Nk+TURN periods. done asserts 1 + 2*CLK_DIV*N cycles after the start-sampling edge. Defaults: N=385, done at cycle 1541.
- data_out holds its value until the next transaction's first RX sample. It is not cleared at start.
- start while busy or in FIN: ignored, no queueing. start in the same cycle done pulses: ignored; start is accepted from the following cycle.
- Input changes on data_in/key_in after acceptance have no effect.
- Counters: a divider counter of width ceil(log2(CLK_DIV))+1, and a 9-bit bit counter that resets at each state change. No wrap occurs within a state.
- Reset mid-transaction: immediate return to reset values. CS rises asynchronously and the slave aborts its frame. No done pulse.
- SDI is treated as synchronous to clk; no metastability synchroniser is included (same clock domain as the slave).

Test Plan:
- Nk=4, CLK_DIV=2, TURN=1, bench AES-encrypt slave model: data_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f -> done at cycle 1541, data_out=69c4e0d86a7b0430d8cdb78070b4c55a, exactly 385 SCLK rises while CS=0.
- Nk=8, same data_in, key_in=000102...1f -> data_out=8ea2b7ca516745bfeafc49904b496089, 384 bits on SDO matching {data,key} MSB-first.
- CLK_DIV=1, loopback slave returning a fixed pattern a5a5...a5 -> data_out=a5a5...a5; SCLK toggles every cycle, no glitches, CS low for exactly 2*N cycles.
- Assert start at cycles 5, 100 and on the done cycle during a transaction -> only one transaction; busy stays high; a second start on the cycle after done is accepted.
- Assert rst at cycle 700 of a transaction -> same cycle CS=1, SCLK=0, busy=0, data_out=0, no done; a new start afterwards completes correctly.
- Slave drives SDI=1 during TURNA, 0 during RX -> data_out=0, confirming sampling begins only in RX.
